// File: rtl/branch_predictor_bht.sv
// Direct-mapped tagged branch history table with saturating counters and targets.
// Define BP_STATS_EN to add saturating resolved/mispredict counters.
module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        bp_clear,
  input  logic        ex_upd_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
`ifdef BP_STATS_EN
  input  logic        ex_mispredict,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispred
`else
  input  logic        ex_mispredict
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [CTR_W-1:0] ex_ctr;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_q[if_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctr = ctr_q[ex_idx];

  // Clear beats training; a pure miss that is not taken leaves the table alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bp_clear) begin
      valid_q <= '0;
    end else if (ex_upd_valid) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ex_ctr != CTR_MAX) ctr_q[ex_idx] <= ex_ctr + CTR_ONE;
          target_q[ex_idx] <= ex_target;
        end else if (ex_ctr != '0) begin
          ctr_q[ex_idx] <= ex_ctr - CTR_ONE;
        end
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        ctr_q[ex_idx]    <= CTR_INIT;
        target_q[ex_idx] <= ex_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (ex_upd_valid) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (ex_mispredict && stat_mispred != '1)
        stat_mispred <= stat_mispred + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc, ex_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht against an array-based reference.
// Covers directed scenarios, async reset and randomized training traffic.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        bp_clear;
  logic        ex_upd_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  branch_predictor_bht dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .bp_clear      (bp_clear),
    .ex_upd_valid  (ex_upd_valid),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
`ifdef BP_STATS_EN
    .ex_mispredict (ex_mispredict),
    .stat_updates  (stat_updates),
    .stat_mispred  (stat_mispred)
`else
    .ex_mispredict (ex_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    int unsigned su;
    int unsigned sm;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: 64 entries, 8-bit tag, 2-bit counter held as plain integers.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_ctr   [64];
  int unsigned m_tgt   [64];
  int unsigned m_su;
  int unsigned m_sm;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_ctr[i]   = 0;
      m_tgt[i]   = 0;
    end
    m_su = 0;
    m_sm = 0;
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] pc, input string nm);
    exp_t e;
    int unsigned i;
    i = idx_of(pc);
    e.hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken = e.hit && (m_ctr[i] >= 2);
    e.tgt   = e.taken ? m_tgt[i] : pc + 32'd4;
    e.su    = m_su;
    e.sm    = m_sm;
    e.tag   = nm;
    return e;
  endfunction

  function automatic void model_update(input bit clr, input bit upd,
                                       input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tg, input bit mis);
    int unsigned i;
    bit hit;
    if (upd) begin
      m_su++;
      if (mis) m_sm++;
    end
    if (clr) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 0;
      return;
    end
    if (!upd) return;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (hit) begin
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = tg;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (tk) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc);
      m_ctr[i]   = 2;
      m_tgt[i]   = tg;
    end
  endfunction

  task automatic step(input string nm, input logic [31:0] pc,
                      input bit upd, input logic [31:0] epc, input bit tk,
                      input logic [31:0] tg, input bit mis, input bit clr);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    if_pc         = pc;
    ex_upd_valid  = upd;
    ex_pc         = epc;
    ex_taken      = tk;
    ex_target     = tg;
    ex_mispredict = mis;
    bp_clear      = clr;
    exp_q.push_back(model_lookup(pc, nm));
    model_update(clr, upd, epc, tk, tg, mis);
  endtask

  // Reset lands mid-cycle with a live update on the EX port.
  task automatic apply_reset(input string nm, input logic [31:0] pc);
    @(posedge clk);
    #1;
    if_pc         = pc;
    ex_upd_valid  = 1'b1;
    ex_pc         = pc;
    ex_taken      = 1'b1;
    ex_target     = 32'h1234_5678;
    ex_mispredict = 1'b1;
    bp_clear      = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    exp_q.push_back(model_lookup(pc, nm));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (pred_hit !== e.hit) begin
        errors++;
        $display("FAIL %s pred_hit got %b want %b", e.tag, pred_hit, e.hit);
      end
      checks++;
      if (pred_taken !== e.taken) begin
        errors++;
        $display("FAIL %s pred_taken got %b want %b", e.tag, pred_taken, e.taken);
      end
      checks++;
      if (pred_target !== e.tgt) begin
        errors++;
        $display("FAIL %s pred_target got %h want %h", e.tag, pred_target, e.tgt);
      end
`ifdef BP_STATS_EN
      checks++;
      if (stat_updates !== e.su || stat_mispred !== e.sm) begin
        errors++;
        $display("FAIL %s stats got %0d/%0d want %0d/%0d",
                 e.tag, stat_updates, stat_mispred, e.su, e.sm);
      end
`endif
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 3) << 8)
       | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return pc;
  endfunction

  initial begin
    rst_n         = 1'b0;
    if_pc         = 32'h40;
    bp_clear      = 1'b0;
    ex_upd_valid  = 1'b0;
    ex_pc         = '0;
    ex_taken      = 1'b0;
    ex_target     = '0;
    ex_mispredict = 1'b0;
    model_reset();

    apply_reset("reset", 32'h40);
    step("alloc", 32'h40, 1, 32'h40, 1, 32'h80, 1, 0);
    step("hit_tk", 32'h40, 0, 0, 0, 0, 0, 0);
    step("nt1", 32'h40, 1, 32'h40, 0, 0, 1, 0);
    step("nt2", 32'h40, 1, 32'h40, 0, 0, 0, 0);
    step("nt3", 32'h40, 1, 32'h40, 0, 0, 0, 0);
    step("ctr0", 32'h40, 0, 0, 0, 0, 0, 0);
    step("alias", 32'h140, 1, 32'h140, 1, 32'h200, 1, 0);
    step("evicted", 32'h40, 0, 0, 0, 0, 0, 0);
    step("replaced", 32'h140, 0, 0, 0, 0, 0, 0);
    step("same_cyc", 32'h40, 1, 32'h40, 1, 32'h300, 0, 0);
    step("next_cyc", 32'h40, 0, 0, 0, 0, 0, 0);
    step("sat_up1", 32'h40, 1, 32'h40, 1, 32'h300, 0, 0);
    step("sat_up2", 32'h40, 1, 32'h40, 1, 32'h304, 0, 0);
    step("sat_dn", 32'h40, 1, 32'h40, 0, 0, 0, 0);
    step("sat_chk", 32'h40, 0, 0, 0, 0, 0, 0);
    step("wrap", 32'hFFFF_FFFC, 1, 32'h80, 1, 32'h500, 0, 0);
    step("clr", 32'h80, 1, 32'hC0, 1, 32'h600, 1, 1);
    step("clr_a", 32'h80, 0, 0, 0, 0, 0, 0);
    step("clr_b", 32'hC0, 0, 0, 0, 0, 0, 0);
    step("clr_c", 32'h40, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset("rnd_rst", rand_pc());
      end else begin
        step("rnd", rand_pc(), ($urandom_range(0, 3) != 0), rand_pc(),
             $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
             $urandom_range(0, 60) == 0);
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
